// File: rtl/seq_alu_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential divide/sqrt unit.
package seq_alu_pkg;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Down-counter must hold WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divsqrt_if.sv
// Start/done handshake and operand/result bus of the divide/sqrt unit.
interface seq_divsqrt_if #(parameter int WIDTH = 8);
  logic             in_start;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_busy;
  logic             out_done;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_rest;
  logic             out_divzero;

  modport master (
    output in_start, in_op, in_a, in_b,
    input  out_busy, out_done, out_result, out_rest, out_divzero
  );

  modport slave (
    input  in_start, in_op, in_a, in_b,
    output out_busy, out_done, out_result, out_rest, out_divzero
  );
endinterface

// File: rtl/divsqrt_step.sv
// Compare-and-subtract cell: x - y plus a flag that is 1 when x >= y.
module divsqrt_step #(
  parameter int W = 10
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] full;

  assign full      = {1'b0, x} - {1'b0, y};
  assign diff      = full[W-1:0];
  assign no_borrow = ~full[W];

endmodule

// File: rtl/seq_divsqrt.sv
// Iterative unsigned divider / integer square root, one result bit per clock.
//
// state   | meaning
// ST_IDLE | waiting for in_start; results from the last op held
// ST_RUN  | iterating; down-counter tracks remaining bits
// ST_DONE | one-cycle done pulse; a new start may be accepted here
module seq_divsqrt
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          in_clk,
  input logic          in_reset,
  seq_divsqrt_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = WIDTH + 2;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rest_q, rest_d;
  logic             divzero_q, divzero_d;

  logic [RW-1:0]    step_x, step_y, step_diff;
  logic             step_nb;
  logic             accept;
  logic             rem_hi_unused;

  // Partial remainders never exceed WIDTH bits between iterations.
  assign rem_hi_unused = ^rem_q[RW-1:WIDTH];

  always_comb begin
    step_x = '0;
    step_y = '0;
    if (op_q == OP_SQRT) begin
      step_x = {rem_q[WIDTH-1:0], opd_q[WIDTH-1 -: 2]};
      step_y = {quo_q, 2'b01};
    end else begin
      step_x = {rem_q[WIDTH:0], opd_q[WIDTH-1]};
      step_y = {2'b00, div_q};
    end
  end

  divsqrt_step #(.W(RW)) u_step (
    .x         (step_x),
    .y         (step_y),
    .diff      (step_diff),
    .no_borrow (step_nb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    opd_d     = opd_q;
    div_d     = div_q;
    result_d  = result_q;
    rest_d    = rest_q;
    divzero_d = divzero_q;
    accept    = bus.in_start && (state_q != ST_RUN);

    case (state_q)
      ST_RUN: begin
        rem_d = step_nb ? step_diff : step_x;
        quo_d = {quo_q[WIDTH-2:0], step_nb};
        opd_d = (op_q == OP_SQRT) ? (opd_q << 2) : (opd_q << 1);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = quo_d;
          rest_d   = rem_d[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      op_d      = bus.in_op;
      opd_d     = bus.in_a;
      div_d     = bus.in_b;
      rem_d     = '0;
      quo_d     = '0;
      divzero_d = 1'b0;
      if (bus.in_op == OP_DIV && bus.in_b == '0) begin
        state_d   = ST_DONE;
        cnt_d     = '0;
        result_d  = '1;
        rest_d    = bus.in_a;
        divzero_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        cnt_d   = (bus.in_op == OP_SQRT) ? CW'(WIDTH / 2) : CW'(WIDTH);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      opd_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      rest_q    <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      opd_q     <= opd_d;
      div_q     <= div_d;
      result_q  <= result_d;
      rest_q    <= rest_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.out_busy    = (state_q == ST_RUN);
  assign bus.out_done    = (state_q == ST_DONE);
  assign bus.out_result  = result_q;
  assign bus.out_rest    = rest_q;
  assign bus.out_divzero = divzero_q;

endmodule

// File: doc/seq_divsqrt.md
# seq_divsqrt

Iterative, width-parametrised integer divider and square-root unit with a start/done handshake. It is the sequential successor to the combinational 8-bit divider and square-root blocks in the ALU. It trades latency for area by resolving one quotient or root bit per clock. Its typical location is behind the ALU operand registers, where long-latency ops are issued and polled.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 4.
- in_clk  in  1  clock; all state changes on the rising edge.
- in_reset  in  1  synchronous, active-high reset.
- in_start  in  1  request a new operation; sampled only when the unit is ready (state IDLE or DONE).
- in_op  in  1  operation select: 0 = unsigned divide in_a / in_b, 1 = integer square root of in_a.
- in_a  in  WIDTH  dividend, or square-root radicand.
- in_b  in  WIDTH  divisor; ignored when in_op = 1.
- out_busy  out  1  1 while in state RUN.
- out_done  out  1  one-cycle pulse; results are valid from this cycle.
- out_result  out  WIDTH  divide: quotient. Sqrt: floor(sqrt(a)), zero-extended from WIDTH/2 bits.
- out_rest  out  WIDTH  divide: remainder. Sqrt: a − root², which always fits in WIDTH bits.
- out_divzero  out  1  set with out_done when a divide had in_b = 0; cleared on the next accepted start.

## Operation
- **States**
  - IDLE → RUN on an accepted start.
  - IDLE → DONE on an accepted start that is a divide with in_b = 0.
  - RUN → DONE when the iteration counter expires.
  - DONE → IDLE after one cycle, unless in_start is 1, in which case the new start is accepted from DONE directly.
- **Start acceptance**
  - On an accepted start, operands and op are latched into internal registers.
  - Input changes after that edge have no effect on the running operation.
- **in_start in RUN** is ignored: no queueing and no error.
- **Divide** uses restoring long division, MSB first, over WIDTH iterations. Each iteration:
  - partial remainder = {rem, next dividend bit};
  - if partial remainder ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
- **Divide by zero** produces out_result = all ones, out_rest = in_a and out_divzero = 1.
- **Sqrt** uses the digit-by-digit restoring method over WIDTH/2 iterations. Each iteration:
  - bring down 2 radicand bits;
  - trial = {root, 2'b01};
  - if remainder ≥ trial, subtract the trial and shift in root bit 1; otherwise shift in 0.
- **Internal widths**
  - The internal remainder register is WIDTH+2 bits, so trial compares never overflow.
  - Outputs are truncated or zero-extended to WIDTH.
- **Output hold**
  - out_result, out_rest and out_divzero hold their last values through IDLE.
  - They change only in the cycle out_done rises.
- **Reset**
  - All outputs and state are 0 and the state is IDLE.
  - Reset in the middle of an operation aborts it with no out_done.
  - Reset has priority over in_start in the same cycle.

## Timing
- Cycle 0 is the edge on which the start is sampled.
- **Divide:** out_busy = 1 in cycles 1 … WIDTH, and out_done = 1 in cycle WIDTH+1.
- **Sqrt:** out_busy = 1 in cycles 1 … WIDTH/2, and out_done = 1 in cycle WIDTH/2+1.
- **Divide by zero:** out_busy stays 0, and out_done = 1 in cycle 1.
- **Back-to-back:** in_start high during the DONE cycle is accepted on that edge, giving a throughput of one op per latency+1 cycles.
- out_done is never high in two consecutive cycles unless a divide-by-zero is started from DONE.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package seq_alu_pkg** holds:
  - OP_DIV / OP_SQRT constants;
  - the state encoding (IDLE, RUN, DONE);
  - a helper function giving the counter width, $clog2(WIDTH)+1.
- **Sub-module divsqrt_step** is a combinational WIDTH+2-bit compare-and-subtract cell.
  - Outputs: difference and a no-borrow flag (msub-style).
  - Both the divide and sqrt datapaths share one instance, muxed by the latched op.
- **Top level** holds:
  - the FSM;
  - a down-counter;
  - the shift registers for quotient/root, remainder and remaining operand bits.

## Test plan
- **Divide:** WIDTH=8, divide 178 / 5 → result 35, rest 3, divzero 0. out_busy high for 8 cycles, out_done in cycle 9.
- **Divide by zero:** WIDTH=8, divide 10 / 0 → result 255, rest 10, divzero 1. out_done in cycle 1, out_busy never high.
- **Sqrt:** WIDTH=8, sqrt 255 → result 15, rest 30, done in cycle 5. Sqrt 16 → 4 rest 0. Sqrt 0 → 0 rest 0.
- **Busy / back-to-back:** start 100 / 7; pulse in_start with 15 / 3 in cycle 4 → ignored, result 14 rest 2. Then start sqrt 15 in the DONE cycle → accepted, result 3 rest 6.
- **Reset mid-op:** start 200 / 9 and assert in_reset in cycle 3 → no out_done, all outputs 0, state IDLE. A following 15 / 3 → 5 rest 0.
- **WIDTH=16:** 65535 / 255 → 257 rest 0 in cycle 17. Sqrt 65535 → 255 rest 510 in cycle 9.
